stack_sequencer: RTL and testbench

Multi-cycle sequencer for the stack-machine datapath. It accepts 32-bit instruction words over a valid/ready handshake and decodes the 6-bit opcode. It then drives the stack's push/pop strobes and the external ALU to execute PUSH, POP and two-operand ALU instructions. It sits between the instruction source and the stack/ALU pair, and reports popped values and sticky error status.

---
 rtl/stack_sequencer.sv | 179 +++++++++++++++++
 tb/tb_stack_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stack_sequencer
// Function : Multi-cycle PUSH / POP / ALU instruction sequencer that drives a
//            stack and an external ALU, with sticky error status.
// Revision : 1.0 - initial release
// ============================================================================
module stack_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic             stack_push,
    output logic             stack_pop,
    output logic [WIDTH-1:0] stack_wdata,
    input  logic [WIDTH-1:0] stack_rdata,
    input  logic             stack_full,
    input  logic             stack_empty,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             err_overflow,
    output logic             err_underflow,
    output logic             err_illegal,
    input  logic             err_clr
);

    localparam logic [2:0] c_FETCH = 3'd0;
    localparam logic [2:0] c_IMM   = 3'd1;
    localparam logic [2:0] c_RD_A  = 3'd2;
    localparam logic [2:0] c_RD_B  = 3'd3;
    localparam logic [2:0] c_EXEC  = 3'd4;
    localparam logic [2:0] c_WR    = 3'd5;

    localparam logic [5:0] c_OP_PUSH = 6'd1;
    localparam logic [5:0] c_OP_POP  = 6'd2;
    localparam logic [5:0] c_OP_ADD  = 6'd3;
    localparam logic [5:0] c_OP_NOR  = 6'd7;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [5:0]       r_opcode;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_err_ovf;
    logic             r_err_unf;
    logic             r_err_ill;
    logic             w_set_ovf;
    logic             w_set_unf;
    logic             w_set_ill;
    logic [5:0]       w_opcode;
    logic             w_accept;

    assign w_opcode = instr[WIDTH-1 -: 6];
    assign w_accept = (r_state == c_FETCH) && instr_valid;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;
        w_set_ill   = 1'b0;
        case (r_state)
            c_FETCH: begin
                if (instr_valid) begin
                    if (w_opcode == c_OP_PUSH) begin
                        w_state_nxt = c_IMM;
                    end else if (w_opcode >= c_OP_POP && w_opcode <= c_OP_NOR) begin
                        w_state_nxt = c_RD_A;
                    end else begin
                        w_set_ill = 1'b1;
                    end
                end
            end
            c_IMM: begin
                if (instr_valid) begin
                    w_state_nxt = c_WR;
                end
            end
            c_RD_A: begin
                if (stack_empty) begin
                    w_set_unf   = 1'b1;
                    w_state_nxt = c_FETCH;
                end else if (r_opcode == c_OP_POP) begin
                    w_state_nxt = c_FETCH;
                end else begin
                    w_state_nxt = c_RD_B;
                end
            end
            c_RD_B: begin
                if (stack_empty) begin
                    w_set_unf   = 1'b1;
                    w_state_nxt = c_FETCH;
                end else begin
                    w_state_nxt = c_EXEC;
                end
            end
            c_EXEC: w_state_nxt = c_WR;
            c_WR: begin
                w_set_ovf   = stack_full;
                w_state_nxt = c_FETCH;
            end
            default: w_state_nxt = c_FETCH;
        endcase
    end

    // Datapath registers and sticky error flags (a same-cycle set beats err_clr)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_opcode    <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_result    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_unf   <= 1'b0;
            r_err_ill   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
                r_opcode <= w_opcode;
            end
            if (r_state == c_IMM && instr_valid) begin
                r_result <= instr;
            end
            if (r_state == c_EXEC) begin
                r_result <= alu_result;
            end
            if (r_state == c_RD_A && !stack_empty) begin
                r_opb <= stack_rdata;
                if (r_opcode == c_OP_POP) begin
                    r_out_data  <= stack_rdata;
                    r_out_valid <= 1'b1;
                end
            end
            if (r_state == c_RD_B && !stack_empty) begin
                r_opa <= stack_rdata;
            end
            r_err_ovf <= w_set_ovf | (r_err_ovf & ~err_clr);
            r_err_unf <= w_set_unf | (r_err_unf & ~err_clr);
            r_err_ill <= w_set_ill | (r_err_ill & ~err_clr);
        end
    end

    assign instr_ready   = (r_state == c_FETCH) || (r_state == c_IMM);
    assign busy          = (r_state != c_FETCH);
    assign stack_pop     = ((r_state == c_RD_A) || (r_state == c_RD_B)) && !stack_empty;
    assign stack_push    = (r_state == c_WR) && !stack_full;
    assign stack_wdata   = r_result;
    assign alu_op        = (r_state == c_EXEC) ? r_opcode[3:0] : 4'd0;
    assign alu_a         = r_opa;
    assign alu_b         = r_opb;
    assign out_data      = r_out_data;
    assign out_valid     = r_out_valid;
    assign err_overflow  = r_err_ovf;
    assign err_underflow = r_err_unf;
    assign err_illegal   = r_err_ill;

endmodule
`default_nettype wire

// File: tb/tb_stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_sequencer
// Function : Scoreboard bench for stack_sequencer with a stack and ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_sequencer;

    localparam int WIDTH = 32;
    localparam logic [31:0] c_PUSH = 32'h0400_0000;
    localparam logic [31:0] c_POP  = 32'h0800_0000;
    localparam logic [31:0] c_ADD  = 32'h0C00_0000;
    localparam logic [31:0] c_SUB  = 32'h1400_0000;
    localparam logic [31:0] c_SLT  = 32'h1800_0000;
    localparam logic [31:0] c_NOR  = 32'h1C00_0000;
    localparam logic [31:0] c_ILL  = 32'hFC00_0000;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] instr;
    logic             instr_valid;
    logic             instr_ready;
    logic             stack_push;
    logic             stack_pop;
    logic [WIDTH-1:0] stack_wdata;
    logic [WIDTH-1:0] stack_rdata;
    logic             stack_full;
    logic             stack_empty;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             busy;
    logic             err_overflow;
    logic             err_underflow;
    logic             err_illegal;
    logic             err_clr;

    stack_sequencer #(.WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .stack_push(stack_push), .stack_pop(stack_pop),
        .stack_wdata(stack_wdata), .stack_rdata(stack_rdata), .stack_full(stack_full),
        .stack_empty(stack_empty), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .err_overflow(err_overflow), .err_underflow(err_underflow),
        .err_illegal(err_illegal), .err_clr(err_clr)
    );

    always #5 clock = ~clock;

    // Stack model, 16 deep
    logic [WIDTH-1:0] mem [0:15];
    logic [4:0]       sp;
    logic             force_full;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (stack_push && sp < 5'd16) begin
            mem[sp[3:0]] <= stack_wdata;
            sp           <= sp + 5'd1;
        end else if (stack_pop && sp != 5'd0) begin
            sp <= sp - 5'd1;
        end
    end

    assign stack_empty = (sp == 5'd0);
    assign stack_full  = force_full || (sp == 5'd16);
    assign stack_rdata = (sp != 5'd0) ? mem[sp[3:0] - 4'd1] : '0;

    // ALU model
    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'd3: alu_result = alu_a + alu_b;
            4'd4: alu_result = alu_a | alu_b;
            4'd5: alu_result = alu_a - alu_b;
            4'd6: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd7: alu_result = ~(alu_a | alu_b);
            default: alu_result = '0;
        endcase
    end

    typedef struct packed {
        logic             is_out;
        logic [WIDTH-1:0] data;
    } ev_t;

    ev_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [3:0]       cap_op;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_check(input logic is_out, input logic [WIDTH-1:0] data);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind %0d data %h expected nothing", is_out, data);
        end else begin
            e = sb.pop_front();
            if (e.is_out !== is_out || e.data !== data) begin
                errors++;
                $display("FAIL sb_event: got kind %0d data %h expected kind %0d data %h",
                         is_out, data, e.is_out, e.data);
            end
        end
    endtask

    // Monitor: consumes scoreboard entries and watches strobe legality
    always @(negedge clock) begin
        if (!reset) begin
            if (stack_push && stack_pop) begin
                checks++;
                errors++;
                $display("FAIL strobe_overlap: got push=1 pop=1 expected exclusive");
            end
            if (stack_pop) chk("pop_nonempty", {31'd0, stack_empty}, 32'd0);
            if (stack_push) sb_check(1'b0, stack_wdata);
            if (out_valid) sb_check(1'b1, out_data);
            if (alu_op != 4'd0) begin
                cap_op = alu_op;
                cap_a  = alu_a;
                cap_b  = alu_b;
            end
        end
    end

    task automatic send(input logic [31:0] w);
        int n;
        @(negedge clock);
        instr = w;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!instr_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got instr_ready=0 expected 1");
        end else begin
            @(posedge clock);
        end
        #1;
        instr_valid = 1'b0;
        instr = '0;
    endtask

    task automatic push_val(input logic [31:0] v);
        send(c_PUSH);
        sb.push_back('{is_out: 1'b0, data: v});
        send(v);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (busy && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected 0");
        end
    endtask

    task automatic reset_pulse();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic clr_err();
        @(negedge clock);
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        reset = 1'b1;
        instr = '0;
        instr_valid = 1'b0;
        err_clr = 1'b0;
        force_full = 1'b0;
        cap_op = '0;
        cap_a = '0;
        cap_b = '0;
        repeat (2) @(negedge clock);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_outs", {23'd0, busy, stack_push, stack_pop, out_valid, alu_op,
                         err_overflow, err_underflow, err_illegal}, 32'd0);
        chk("rst_data", out_data | alu_a | alu_b | stack_wdata, 32'd0);
        reset = 1'b0;

        // 5 + 3 = 8
        push_val(32'd5);
        push_val(32'd3);
        sb.push_back('{is_out: 1'b0, data: 32'd8});
        send(c_ADD);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (busy) cnt++;
            else break;
        end
        chk("add_busy_cycles", cnt, 32'd4);
        chk("add_depth", {27'd0, sp}, 32'd1);
        chk("add_tos", stack_rdata, 32'd8);

        // SUB, SLT, NOR with operand ordering
        reset_pulse();
        push_val(32'd3);
        push_val(32'd5);
        sb.push_back('{is_out: 1'b0, data: 32'hFFFF_FFFE});
        send(c_SUB);
        wait_idle();
        chk("sub_op", {28'd0, cap_op}, 32'd5);
        chk("sub_a", cap_a, 32'd3);
        chk("sub_b", cap_b, 32'd5);
        push_val(32'd3);
        push_val(32'd5);
        sb.push_back('{is_out: 1'b0, data: 32'd1});
        send(c_SLT);
        wait_idle();
        chk("slt_op", {28'd0, cap_op}, 32'd6);
        push_val(32'h0000_00F0);
        push_val(32'h0000_000F);
        sb.push_back('{is_out: 1'b0, data: 32'hFFFF_FF00});
        send(c_NOR);
        wait_idle();
        chk("nor_op", {28'd0, cap_op}, 32'd7);

        // POP
        reset_pulse();
        push_val(32'hDEAD_BEEF);
        sb.push_back('{is_out: 1'b1, data: 32'hDEAD_BEEF});
        send(c_POP);
        wait_idle();
        @(negedge clock);
        chk("pop_data", out_data, 32'hDEAD_BEEF);
        chk("pop_empty", {31'd0, stack_empty}, 32'd1);

        // Underflow
        reset_pulse();
        send(c_POP);
        wait_idle();
        chk("unf_pop", {31'd0, err_underflow}, 32'd1);
        clr_err();
        chk("unf_clr", {31'd0, err_underflow}, 32'd0);
        push_val(32'd1);
        send(c_ADD);
        wait_idle();
        @(negedge clock);
        chk("unf_add", {31'd0, err_underflow}, 32'd1);
        chk("unf_depth", {27'd0, sp}, 32'd0);
        clr_err();
        chk("unf_clr2", {31'd0, err_underflow}, 32'd0);

        // Overflow and illegal opcode
        force_full = 1'b1;
        send(c_PUSH);
        send(32'd7);
        wait_idle();
        chk("ovf_flag", {31'd0, err_overflow}, 32'd1);
        force_full = 1'b0;
        send(c_ILL);
        @(negedge clock);
        chk("ill_flag", {31'd0, err_illegal}, 32'd1);
        chk("ill_busy", {31'd0, busy}, 32'd0);
        chk("ovf_sticky", {31'd0, err_overflow}, 32'd1);
        clr_err();
        chk("clr_all", {29'd0, err_overflow, err_underflow, err_illegal}, 32'd0);

        // IMM wait, then reset mid-ADD
        reset_pulse();
        send(c_PUSH);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("imm_wait", {30'd0, instr_ready, busy}, 32'd3);
        end
        sb.push_back('{is_out: 1'b0, data: 32'd9});
        send(32'd9);
        push_val(32'd4);
        send(c_ADD);
        @(negedge clock);
        @(negedge clock);
        chk("rdb_pop", {31'd0, stack_pop}, 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_outs", {23'd0, busy, stack_push, stack_pop, out_valid, alu_op,
                          err_overflow, err_underflow, err_illegal}, 32'd0);
        chk("arst_ready", {31'd0, instr_ready}, 32'd1);
        chk("arst_data", out_data | alu_a | alu_b | stack_wdata, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        chk("post_rst_depth", {27'd0, sp}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
